// File: rtl/approx_mul_rr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : approx_mul_rr_sched                                          |
// | Description : Round-robin scheduler sharing one 2-stage column-truncated   |
// |               approximate multiplier among NREQ valid/ready requesters.    |
// |               Results return tagged with the issuing requester id.         |
// |               Optional macro EXACT_BYPASS_EN adds req_exact / out_exact.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module approx_mul_rr_sched #(
  parameter int W    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int TW   = $clog2(2*W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [TW-1:0]     cfg_theta,
`ifdef EXACT_BYPASS_EN
  input  logic [NREQ-1:0]   req_exact,
  output logic              out_exact,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    out_z,
  output logic [IDW-1:0]    out_id,
  output logic              busy
);

  localparam int c_pw = 2*W;
  localparam int c_aw = IDW + 1;
  localparam logic [c_pw-1:0] c_one     = c_pw'(1);
  localparam logic [NREQ-1:0] c_req_one = NREQ'(1);

  logic [IDW-1:0]  r_ptr;
  logic            r_v1;
  logic [W-1:0]    r_x1;
  logic [W-1:0]    r_y1;
  logic [TW-1:0]   r_th1;
  logic [IDW-1:0]  r_id1;
  logic            r_out_valid;
  logic [c_pw-1:0] r_out_z;
  logic [IDW-1:0]  r_out_id;

  logic            w_adv;
  logic            w_found;
  logic [IDW-1:0]  w_gid;
  logic [c_aw-1:0] w_cand;
  logic            w_accept;
  logic [c_pw-1:0] w_prod;

`ifdef EXACT_BYPASS_EN
  logic r_ex1;
  logic r_out_exact;
  assign out_exact = r_out_exact;
`endif

  // Whole pipeline moves when the output slot is empty or being drained; held in reset.
  assign w_adv = (!r_out_valid || out_ready) && rst_n;

  // Circular search starting one past the last winner; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_cand  = '0;
    for (int o = 1; o <= NREQ; o++) begin
      w_cand = {1'b0, r_ptr} + c_aw'(o);
      if (w_cand >= c_aw'(NREQ)) w_cand = w_cand - c_aw'(NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gid   = w_cand[IDW-1:0];
      end
    end
  end

  assign w_accept  = w_found && w_adv;
  assign req_ready = w_accept ? (c_req_one << w_gid) : '0;

  // Round-robin pointer remembers the last accepted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ptr <= IDW'(NREQ-1);
    else if (w_accept) r_ptr <= w_gid;
  end

  // S1: capture granted operands, threshold and id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_x1  <= '0;
      r_y1  <= '0;
      r_th1 <= '0;
      r_id1 <= '0;
`ifdef EXACT_BYPASS_EN
      r_ex1 <= 1'b0;
`endif
    end else if (w_adv) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_x1  <= req_x[w_gid*W +: W];
        r_y1  <= req_y[w_gid*W +: W];
        r_id1 <= w_gid;
`ifdef EXACT_BYPASS_EN
        r_th1 <= req_exact[w_gid] ? '0 : cfg_theta;
        r_ex1 <= req_exact[w_gid];
`else
        r_th1 <= cfg_theta;
`endif
      end
    end
  end

  // Truncated product: partial-product bit (i,j) kept only when its column i+j >= theta.
  always_comb begin
    w_prod = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if (r_y1[i] && r_x1[j] && ((i + j) >= int'(r_th1)))
          w_prod = w_prod + (c_one << (i + j));
      end
    end
  end

  // S2: output register; a bubble in S1 clears out_valid, data held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
      r_out_id    <= '0;
`ifdef EXACT_BYPASS_EN
      r_out_exact <= 1'b0;
`endif
    end else if (w_adv) begin
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_out_z  <= w_prod;
        r_out_id <= r_id1;
`ifdef EXACT_BYPASS_EN
        r_out_exact <= r_ex1;
`endif
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_z     = r_out_z;
  assign out_id    = r_out_id;
  assign busy      = r_v1 | r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_approx_mul_rr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_approx_mul_rr_sched                                       |
// | Description : Directed, table-driven bench for approx_mul_rr_sched.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_approx_mul_rr_sched;

  localparam int W    = 8;
  localparam int NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [3:0]        cfg_theta;
  logic [NREQ-1:0]   req_exact;
  logic              out_exact;
  logic              out_valid;
  logic              out_ready;
  logic [2*W-1:0]    out_z;
  logic [1:0]        out_id;
  logic              busy;

  approx_mul_rr_sched #(.W(W), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .cfg_theta (cfg_theta),
`ifdef EXACT_BYPASS_EN
    .req_exact (req_exact),
    .out_exact (out_exact),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_id    (out_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         k;
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] th;
    logic [15:0] ez;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] z;
  } exp_t;

  vec_t tbl[8];
  exp_t q[$];
  logic mon_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for streaming traffic (theta=0, so expected result is the exact product).
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          exp_t e;
          e.id = 2'(k);
          e.z  = 16'(req_x[k*W +: W]) * 16'(req_y[k*W +: W]);
          q.push_back(e);
        end
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got id %0d z 0x%0h with nothing outstanding", out_id, out_z);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_id", 32'(out_id), 32'(e.id));
          chk("sb_z",  32'(out_z),  32'(e.z));
        end
      end
    end
  end

  // One isolated transaction from requester k; called just after a rising edge while idle.
  task automatic run_vec(input vec_t v);
    req_valid = '0;
    req_valid[v.k] = 1'b1;
    req_x = '0;
    req_y = '0;
    req_x[v.k*W +: W] = v.x;
    req_y[v.k*W +: W] = v.y;
    cfg_theta = v.th;
    @(negedge clk);
    chk("vec_ready", 32'(req_ready), 32'(4'b0001 << v.k));
    @(posedge clk); #1;
    req_valid = '0;
    cfg_theta = ~v.th;
    chk("vec_s1_valid", 32'(out_valid), 32'd0);
    chk("vec_s1_busy",  32'(busy),      32'd1);
    @(posedge clk); #1;
    chk("vec_valid", 32'(out_valid), 32'd1);
    chk("vec_z",     32'(out_z),     32'(v.ez));
    chk("vec_id",    32'(out_id),    32'(v.k));
    @(posedge clk); #1;
    chk("vec_drain", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] held_z;
    logic [1:0]  held_id;
    rst_n = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    cfg_theta = '0;
    req_exact = '0;
    out_ready = 1'b1;
    mon_en = 1'b0;

    tbl[0] = '{0, 8'd13, 8'd11, 4'd0,  16'd143};
    tbl[1] = '{0, 8'hFF, 8'h80, 4'd10, 16'h7C00};
    tbl[2] = '{0, 8'hFF, 8'h01, 4'd10, 16'h0000};
    tbl[3] = '{0, 8'hFF, 8'h03, 4'd8,  16'h0100};
    tbl[4] = '{2, 8'hFF, 8'hFF, 4'd0,  16'hFE01};
    tbl[5] = '{3, 8'hFF, 8'hFF, 4'd15, 16'h0000};
    tbl[6] = '{1, 8'hFF, 8'hFF, 4'd14, 16'h4000};
    tbl[7] = '{2, 8'h0F, 8'h0F, 4'd4,  16'h00B0};

    // Reset state, with requests pending to show req_ready stays low.
    #3;
    req_valid = '1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_z",     32'(out_z),     32'd0);
    chk("rst_out_id",    32'(out_id),    32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Fill both stages with streaming traffic, freeze, then reset mid-flight.
    req_x = {8'd8, 8'd7, 8'd6, 8'd5};
    req_y = {8'd12, 8'd11, 8'd10, 8'd9};
    cfg_theta = 4'd0;
    req_valid = '1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_busy",      32'(busy),      32'd1);
    mon_en = 1'b0;
    q.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy",      32'(busy),      32'd0);
    chk("midrst_ready",     32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    mon_en = 1'b1;

    // All four requesters valid: grants rotate starting from requester 0.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (c % 4)));
    end

    // Backpressure: outputs frozen, no grants, then resume with order preserved.
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    held_z  = out_z;
    held_id = out_id;
    chk("stall_valid0", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_z",     32'(out_z),     32'(held_z));
      chk("stall_id",    32'(out_id),    32'(held_id));
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    req_valid = '0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #2;
      if (!out_valid && q.size() == 0) break;
    end
    chk("drain_queue", 32'(q.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_busy",  32'(busy),      32'd0);
    mon_en = 1'b0;

`ifdef EXACT_BYPASS_EN
    // Exact bypass overrides a threshold that would otherwise zero the product.
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_exact = 4'b0001;
    req_x = '0;
    req_y = '0;
    req_x[7:0] = 8'hFF;
    req_y[7:0] = 8'hFF;
    cfg_theta = 4'd15;
    @(posedge clk); #1;
    req_valid = '0;
    req_exact = '0;
    @(posedge clk); #1;
    chk("exact_valid", 32'(out_valid), 32'd1);
    chk("exact_z",     32'(out_z),     32'hFE01);
    chk("exact_flag",  32'(out_exact), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
